// File: rtl/tcm_port_arbiter.sv
// Two-master (LSU / debug) arbiter for the instruction TCM port, with debug starvation guard and exclusive lock.
// Optional `ARB_PERF_CNT_EN adds saturating conflict and LSU-stall counters.
module tcm_port_arbiter #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [DATA_W-1:0] lsu_wdata_i,
   output logic              lsu_gnt_o,
   output logic              lsu_rvalid_o,
   output logic              lsu_stall_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   input  logic              dbg_lock_i,
   output logic              dbg_gnt_o,
   output logic              dbg_rvalid_o,
   output logic              dbg_locked_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [DATA_W-1:0] rdata_o
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       conflict_cnt_o,
   output logic [31:0]       lsu_stall_cnt_o
`endif
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [0:0] ST_ARB    = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              lsu_rvalid_q, dbg_rvalid_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              lsu_gnt, dbg_gnt;

   // Grant decision; grants are suppressed while reset is asserted
   always_comb begin
      lsu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (rst) begin
         lsu_gnt = 1'b0;
         dbg_gnt = 1'b0;
      end else begin
         case (state_q)
            ST_ARB: begin
               if (lsu_req_i && !(dbg_req_i && (starve_q >= STARVE_MAX))) begin
                  lsu_gnt = 1'b1;
               end else begin
                  dbg_gnt = dbg_req_i;
               end
            end
            ST_LOCKED: dbg_gnt = dbg_req_i;
            default: begin
               lsu_gnt = 1'b0;
               dbg_gnt = 1'b0;
            end
         endcase
      end
   end

   // Next-state for lock FSM and debug starvation counter
   always_comb begin
      state_d  = dbg_lock_i ? ST_LOCKED : ST_ARB;
      starve_d = '0;
      if (dbg_req_i && !dbg_gnt) begin
         starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + CNT_W'(1);
      end else begin
         starve_d = '0;
      end
   end

   // Memory-side mux; address and data hold their last granted value when idle
   always_comb begin
      mem_we_o    = 1'b0;
      mem_addr_o  = addr_q;
      mem_wdata_o = wdata_q;
      if (lsu_gnt) begin
         mem_we_o    = lsu_we_i;
         mem_addr_o  = lsu_addr_i;
         mem_wdata_o = lsu_wdata_i;
      end else if (dbg_gnt) begin
         mem_we_o    = dbg_we_i;
         mem_addr_o  = dbg_addr_i;
         mem_wdata_o = dbg_wdata_i;
      end else begin
         mem_we_o = 1'b0;
      end
   end

   // Arbiter state, read-valid pipeline and held memory address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_ARB;
         starve_q     <= '0;
         lsu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         lsu_rvalid_q <= lsu_gnt && !lsu_we_i;
         dbg_rvalid_q <= dbg_gnt && !dbg_we_i;
         addr_q       <= mem_addr_o;
         wdata_q      <= mem_wdata_o;
      end
   end

   assign lsu_gnt_o    = lsu_gnt;
   assign dbg_gnt_o    = dbg_gnt;
   assign lsu_stall_o  = lsu_req_i && !lsu_gnt;
   assign lsu_rvalid_o = lsu_rvalid_q;
   assign dbg_rvalid_o = dbg_rvalid_q;
   assign dbg_locked_o = (state_q == ST_LOCKED);
   assign rdata_o      = mem_rdata_i;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] conflict_q, stall_cnt_q;

   // Saturating performance counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_q  <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         if (lsu_req_i && dbg_req_i && (conflict_q != 32'hFFFF_FFFF)) begin
            conflict_q <= conflict_q + 32'd1;
         end
         if (lsu_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign conflict_cnt_o  = conflict_q;
   assign lsu_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Randomized plus directed bench for tcm_port_arbiter against a cycle-level reference model.
module tb_tcm_port_arbiter;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic lsu_req = 1'b0, lsu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
   logic [AW-1:0] lsu_addr = '0, dbg_addr = '0;
   logic [DW-1:0] lsu_wdata = '0, dbg_wdata = '0, mem_rdata = '0;
   logic lsu_gnt, lsu_rvalid, lsu_stall, dbg_gnt, dbg_rvalid, dbg_locked, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, rdata;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] conflict_cnt, lsu_stall_cnt;
`endif

   always #5 clk = ~clk;

   tcm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
      .lsu_gnt_o(lsu_gnt), .lsu_rvalid_o(lsu_rvalid), .lsu_stall_o(lsu_stall),
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
      .dbg_lock_i(dbg_lock), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_locked_o(dbg_locked),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .rdata_o(rdata)
`ifdef ARB_PERF_CNT_EN
      , .conflict_cnt_o(conflict_cnt), .lsu_stall_cnt_o(lsu_stall_cnt)
`endif
   );

   int n_checks = 0;
   int n_pass = 0;

   // reference model state
   bit m_locked, m_pend_l, m_pend_d;
   int m_wait;
   logic [AW-1:0] m_addr;
   int m_conflict, m_stall;
   bit e_gl, e_gd;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_locked = 0; m_pend_l = 0; m_pend_d = 0; m_wait = 0;
      m_addr = '0; m_conflict = 0; m_stall = 0;
   endtask

   // drive one cycle's inputs at the falling edge and check every output against the model
   task automatic drive_check(input bit lr, input bit lw, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                              input bit dr, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                              input bit lk);
      logic [AW-1:0] ea;
      @(negedge clk);
      lsu_req = lr; lsu_we = lw; lsu_addr = la; lsu_wdata = ld;
      dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_lock = lk;
      mem_rdata = $urandom;
      #1;
      if (m_locked) begin e_gd = dr; e_gl = 0; end
      else if (lr && dr) begin e_gd = (m_wait >= LIMIT); e_gl = !e_gd; end
      else begin e_gl = lr; e_gd = dr; end
      ea = e_gl ? la : (e_gd ? da : m_addr);
      check_eq("lsu_gnt", 32'(lsu_gnt), 32'(e_gl));
      check_eq("dbg_gnt", 32'(dbg_gnt), 32'(e_gd));
      check_eq("lsu_stall", 32'(lsu_stall), 32'(lr && !e_gl));
      check_eq("mem_we", 32'(mem_we), 32'((e_gl && lw) || (e_gd && dw)));
      check_eq("mem_addr", 32'(mem_addr), 32'(ea));
      if (e_gl || e_gd) check_eq("mem_wdata", mem_wdata, e_gl ? ld : dd);
      check_eq("lsu_rvalid", 32'(lsu_rvalid), 32'(m_pend_l));
      check_eq("dbg_rvalid", 32'(dbg_rvalid), 32'(m_pend_d));
      check_eq("dbg_locked", 32'(dbg_locked), 32'(m_locked));
      check_eq("rdata", rdata, mem_rdata);
   endtask

   task automatic commit();
      @(posedge clk);
      m_pend_l = e_gl && !lsu_we;
      m_pend_d = e_gd && !dbg_we;
      if (e_gl) m_addr = lsu_addr;
      else if (e_gd) m_addr = dbg_addr;
      m_wait = (dbg_req && !e_gd) ? ((m_wait < LIMIT) ? m_wait + 1 : LIMIT) : 0;
      m_locked = dbg_lock;
      if (lsu_req && dbg_req) m_conflict++;
      if (lsu_req && !e_gl) m_stall++;
   endtask

   task automatic step(input bit lr, input bit lw, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input bit dr, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                       input bit lk);
      drive_check(lr, lw, la, ld, dr, dw, da, dd, lk);
      commit();
   endtask

   // assert reset now (inputs left as they are), check forced outputs, release after n edges
   task automatic apply_reset(input int n);
      rst = 1'b1;
      #1;
      check_eq("rst_lsu_gnt", 32'(lsu_gnt), 32'd0);
      check_eq("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
      check_eq("rst_mem_we", 32'(mem_we), 32'd0);
      repeat (n) @(posedge clk);
      #1;
      check_eq("rst_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
      check_eq("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
      check_eq("rst_locked", 32'(dbg_locked), 32'd0);
      check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
      model_reset();
      @(negedge clk);
      lsu_req = 0; dbg_req = 0; dbg_lock = 0;
      rst = 1'b0;
   endtask

   initial begin
      bit lr, lw, dr, dw, lk;
      logic [AW-1:0] la, da;
      logic [DW-1:0] ld, dd;
      model_reset();
      lsu_req = 1'b1; dbg_req = 1'b1;
      @(negedge clk);
      apply_reset(2);

      // LSU read at 0x010, rvalid exactly one cycle later
      step(1, 0, 12'h010, 32'd0, 0, 0, 12'h0, 32'd0, 0);
      check_eq("dir_read_addr", 32'(mem_addr), 32'h010);
      step(0, 0, 12'h000, 32'd0, 0, 0, 12'h0, 32'd0, 0);
      check_eq("dir_rvalid_n1", 32'(lsu_rvalid), 32'd1);
      step(0, 0, 12'h000, 32'd0, 0, 0, 12'h0, 32'd0, 0);
      check_eq("dir_rvalid_n2", 32'(lsu_rvalid), 32'd0);

      // starvation: LSU 4 times, debug on the 5th, then LSU
      for (int i = 0; i < 6; i++) begin
         drive_check(1, 0, 12'(i), 32'd0, 1, 0, 12'h555, 32'd0, 0);
         check_eq("dir_starve_dgnt", 32'(dbg_gnt), (i == 4) ? 32'd1 : 32'd0);
         commit();
      end

      // lock while LSU requests, then release
      step(1, 0, 12'h020, 32'd0, 0, 0, 12'h0, 32'd0, 1);
      for (int i = 0; i < 3; i++) begin
         drive_check(1, 0, 12'h021, 32'd0, 0, 0, 12'h0, 32'd0, (i < 2));
         check_eq("dir_lock_stall", 32'(lsu_stall), 32'd1);
         commit();
      end
      drive_check(1, 0, 12'h021, 32'd0, 0, 0, 12'h0, 32'd0, 0);
      check_eq("dir_unlock_gnt", 32'(lsu_gnt), 32'd1);
      commit();

      // debug write to top of memory
      drive_check(0, 0, 12'h0, 32'd0, 1, 1, 12'hFFF, 32'hDEADBEEF, 0);
      check_eq("dir_dbg_wdata", mem_wdata, 32'hDEADBEEF);
      commit();
      step(0, 0, 12'h0, 32'd0, 0, 0, 12'h0, 32'd0, 0);
      check_eq("dir_dbg_no_rvalid", 32'(dbg_rvalid), 32'd0);

      // reset during a read grant, with the lock held
      step(0, 0, 12'h0, 32'd0, 0, 0, 12'h0, 32'd0, 1);
      drive_check(1, 0, 12'h033, 32'd0, 1, 0, 12'h044, 32'd0, 1);
      apply_reset(1);
      step(0, 0, 12'h0, 32'd0, 0, 0, 12'h0, 32'd0, 0);

      // randomized traffic; requests held until granted
      lr = 0; dr = 0; lk = 0; lw = 0; dw = 0; la = '0; da = '0; ld = '0; dd = '0;
      for (int i = 0; i < 400; i++) begin
         if (!(lr && !e_gl)) begin
            lr = ($urandom_range(0, 3) != 0); lw = $urandom_range(0, 1) == 1;
            la = AW'($urandom); ld = $urandom;
         end
         if (!(dr && !e_gd)) begin
            dr = ($urandom_range(0, 2) != 0); dw = $urandom_range(0, 1) == 1;
            da = AW'($urandom); dd = $urandom;
         end
         if ($urandom_range(0, 9) == 0) lk = !lk;
         step(lr, lw, la, ld, dr, dw, da, dd, lk);
      end
`ifdef ARB_PERF_CNT_EN
      #1;
      check_eq("conflict_cnt", conflict_cnt, 32'(m_conflict));
      check_eq("lsu_stall_cnt", lsu_stall_cnt, 32'(m_stall));
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
